avg_channel_scheduler: RTL and testbench



---
 rtl/avg_sched_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/avg_channel_scheduler.sv | 158 +++++++++++++++
 tb/tb_avg_channel_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avg_sched_pkg.sv
// Shared helpers for the averaging scheduler: accumulator widths and
// the round-robin successor used by the channel arbiters.
package avg_sched_pkg;

   // Block sum must hold 2^avg_w full-scale samples without overflow.
   function automatic int sum_width(input int data_w, input int avg_w);
      return data_w + avg_w;
   endfunction

   // Moving average carries extra fractional headroom for the decay term.
   function automatic int ave_width(input int data_w, input int avg_w, input int mavg_w);
      return data_w + avg_w + mavg_w;
   endfunction

   // Next index in a round-robin ring of n entries.
   function automatic int rr_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts just after the
// previously granted channel. clear parks the pointer so channel 0 is next.
module rr_arbiter
   import avg_sched_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int CH_WIDTH = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic [NUM_CH-1:0]   pend_i,
   output logic                grant_valid_o,
   output logic [CH_WIDTH-1:0] grant_idx_o
);

   logic [CH_WIDTH-1:0] last_grant_q;
   logic [CH_WIDTH-1:0] last_grant_d;
   logic [CH_WIDTH-1:0] cand;

   // Walk the ring once from last_grant+1 and take the first pending channel.
   always_comb begin
      grant_valid_o = 1'b0;
      grant_idx_o   = '0;
      cand          = last_grant_q;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = CH_WIDTH'(rr_next(int'(cand), NUM_CH));
         if (!grant_valid_o && pend_i[cand]) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = cand;
         end
      end
   end

   // Pointer follows each grant; clear takes precedence over a same-cycle grant.
   always_comb begin
      last_grant_d = last_grant_q;
      if (clear)
         last_grant_d = CH_WIDTH'(NUM_CH - 1);
      else if (grant_valid_o)
         last_grant_d = grant_idx_o;
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (!reset_n)
         last_grant_q <= CH_WIDTH'(NUM_CH - 1);
      else
         last_grant_q <= last_grant_d;
   end

endmodule

// File: rtl/avg_channel_scheduler.sv
// Shared block-average + moving-average engine time-multiplexed across
// NUM_CH sample streams. One-deep hold register per channel, round-robin
// grant into per-channel accumulator arrays, tagged output stream.
module avg_channel_scheduler
   import avg_sched_pkg::*;
#(
   parameter int NUM_CH               = 4,
   parameter int CH_WIDTH             = 2,
   parameter int DATA_WIDTH           = 10,
   parameter int AVERAGE_WIDTH        = 9,
   parameter int MOVING_AVERAGE_WIDTH = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         clear,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]            in_valid,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic [CH_WIDTH-1:0]          out_ch,
   output logic                         out_valid,
   output logic [NUM_CH-1:0]            ovf,
   input  logic                         ovf_clr
);

   localparam int SW = sum_width(DATA_WIDTH, AVERAGE_WIDTH);
   localparam int AW = ave_width(DATA_WIDTH, AVERAGE_WIDTH, MOVING_AVERAGE_WIDTH);

   logic signed [DATA_WIDTH-1:0]    hold_q [NUM_CH];
   logic signed [DATA_WIDTH-1:0]    hold_d [NUM_CH];
   logic [NUM_CH-1:0]               pend_q, pend_d;
   logic [AVERAGE_WIDTH-1:0]        cnt_q  [NUM_CH];
   logic [AVERAGE_WIDTH-1:0]        cnt_d  [NUM_CH];
   logic signed [SW-1:0]            sum_q  [NUM_CH];
   logic signed [SW-1:0]            sum_d  [NUM_CH];
   logic signed [AW-1:0]            ave_q  [NUM_CH];
   logic signed [AW-1:0]            ave_d  [NUM_CH];
   logic [NUM_CH-1:0]               ovf_q, ovf_d, ovf_set;
   logic signed [DATA_WIDTH-1:0]    out_data_q, out_data_d;
   logic [CH_WIDTH-1:0]             out_ch_q, out_ch_d;
   logic                            out_valid_q, out_valid_d;

   logic                            grant_valid;
   logic [CH_WIDTH-1:0]             grant_idx;
   logic [NUM_CH-1:0]               grant_oh;

   logic signed [DATA_WIDTH-1:0]    hold_g;
   logic signed [SW-1:0]            s_ext, blk_sum, blk_sh;
   logic signed [AW-1:0]            blk_ext, ave_g, ave_new;

   rr_arbiter #(
      .NUM_CH   (NUM_CH),
      .CH_WIDTH (CH_WIDTH)
   ) u_arb (
      .clk           (clk),
      .reset_n       (reset_n),
      .clear         (clear),
      .pend_i        (pend_q),
      .grant_valid_o (grant_valid),
      .grant_idx_o   (grant_idx)
   );

   assign grant_oh = grant_valid ? (NUM_CH'(1) << grant_idx) : '0;

   // Engine datapath for the granted channel; every term kept signed so shifts floor.
   assign hold_g  = hold_q[grant_idx];
   assign s_ext   = {{AVERAGE_WIDTH{hold_g[DATA_WIDTH-1]}}, hold_g};
   assign blk_sum = sum_q[grant_idx] + s_ext;
   assign blk_sh  = blk_sum >>> AVERAGE_WIDTH;
   assign blk_ext = {{MOVING_AVERAGE_WIDTH{blk_sh[SW-1]}}, blk_sh};
   assign ave_g   = ave_q[grant_idx];
   assign ave_new = ave_g - (ave_g >>> MOVING_AVERAGE_WIDTH) + blk_ext;

   // Capture/overrun per channel, accumulate the granted sample, then apply clear.
   always_comb begin
      hold_d      = hold_q;
      pend_d      = pend_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      ave_d       = ave_q;
      ovf_set     = '0;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = 1'b0;

      for (int k = 0; k < NUM_CH; k++) begin
         if (in_valid[k] && (!pend_q[k] || grant_oh[k])) begin
            hold_d[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
            pend_d[k] = 1'b1;
         end else if (grant_oh[k]) begin
            pend_d[k] = 1'b0;
         end else if (in_valid[k]) begin
            ovf_set[k] = 1'b1;
         end
      end

      if (grant_valid) begin
         if (cnt_q[grant_idx] != {AVERAGE_WIDTH{1'b1}}) begin
            cnt_d[grant_idx] = cnt_q[grant_idx] + AVERAGE_WIDTH'(1);
            sum_d[grant_idx] = blk_sum;
         end else begin
            cnt_d[grant_idx] = '0;
            sum_d[grant_idx] = '0;
            ave_d[grant_idx] = ave_new;
            out_data_d       = DATA_WIDTH'(ave_new >>> MOVING_AVERAGE_WIDTH);
            out_ch_d         = grant_idx;
            out_valid_d      = 1'b1;
         end
      end

      // clear wipes channel state and drops any same-cycle grant or capture.
      if (clear) begin
         for (int k = 0; k < NUM_CH; k++) begin
            hold_d[k] = '0;
            cnt_d[k]  = '0;
            sum_d[k]  = '0;
            ave_d[k]  = '0;
         end
         pend_d      = '0;
         ovf_set     = '0;
         out_data_d  = '0;
         out_ch_d    = '0;
         out_valid_d = 1'b0;
      end

      ovf_d = (ovf_clr ? '0 : ovf_q) | ovf_set;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hold_q      <= '{default: '0};
         pend_q      <= '0;
         cnt_q       <= '{default: '0};
         sum_q       <= '{default: '0};
         ave_q       <= '{default: '0};
         ovf_q       <= '0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         ave_q       <= ave_d;
         ovf_q       <= ovf_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_avg_channel_scheduler.sv
// Bench for avg_channel_scheduler: directed stimulus pushes hand-computed
// averages into a scoreboard; a negedge monitor pops on every out_valid.
module tb_avg_channel_scheduler;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;
   localparam int DW     = 10;
   localparam int AVW    = 2;
   localparam int MAW    = 2;

   logic                    clk;
   logic                    reset_n;
   logic                    clear;
   logic [NUM_CH*DW-1:0]    in_data;
   logic [NUM_CH-1:0]       in_valid;
   logic signed [DW-1:0]    out_data;
   logic [CH_W-1:0]         out_ch;
   logic                    out_valid;
   logic [NUM_CH-1:0]       ovf;
   logic                    ovf_clr;

   typedef struct {
      int ch;
      int data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   avg_channel_scheduler #(
      .NUM_CH               (NUM_CH),
      .CH_WIDTH             (CH_W),
      .DATA_WIDTH           (DW),
      .AVERAGE_WIDTH        (AVW),
      .MOVING_AVERAGE_WIDTH (MAW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every out_valid must match the oldest expectation.
   always @(negedge clk) begin
      if (out_valid) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out: got ch=%0d data=%0d, required no output",
                     out_ch, out_data);
         end else begin
            mon_e = sb.pop_front();
            if (int'(out_ch) != mon_e.ch || int'(out_data) != mon_e.data) begin
               failures++;
               $display("FAIL out_stream: got ch=%0d data=%0d, required ch=%0d data=%0d",
                        out_ch, out_data, mon_e.ch, mon_e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ch(input int ch, input int v);
      in_data[ch*DW +: DW] = DW'(v);
      in_valid[ch]         = 1'b1;
   endtask

   // One sample on one channel, then idle to the next 4-cycle slot.
   task automatic send_spaced(input int ch, input int v);
      set_ch(ch, v);
      cyc(1);
      in_valid = '0;
      cyc(3);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      cyc(1);
   endtask

   initial begin
      int firsts[4];
      firsts = '{200, 40, 80, 120};

      reset_n  = 1'b0;
      clear    = 1'b0;
      in_data  = '0;
      in_valid = '0;
      ovf_clr  = 1'b0;
      cyc(3);
      chk("rst_out_data",  int'(out_data),  0);
      chk("rst_out_ch",    int'(out_ch),    0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_ovf",       int'(ovf),       0);
      reset_n = 1'b1;
      cyc(1);

      // ch0 constant 100: blocks give 25 then 43; first output 2 cycles after 4th sample.
      sb.push_back('{ch: 0, data: 25});
      sb.push_back('{ch: 0, data: 43});
      for (int i = 0; i < 8; i++) begin
         set_ch(0, 100);
         cyc(1);
         in_valid = '0;
         if (i == 3) begin
            cyc(1);
            chk("latency_out_valid", int'(out_valid), 1);
            cyc(2);
         end else begin
            cyc(3);
         end
      end
      cyc(2);

      // ch2 constant -100: floor shifts give -25 then -44.
      do_clear();
      sb.push_back('{ch: 2, data: -25});
      sb.push_back('{ch: 2, data: -44});
      for (int i = 0; i < 8; i++) send_spaced(2, -100);
      cyc(2);

      // Prefill 3 samples of 100 on all channels at the 4-cycle fairness spacing.
      do_clear();
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < NUM_CH; k++) set_ch(k, 100);
         cyc(1);
         in_valid = '0;
         cyc(3);
      end
      cyc(4);
      chk("ovf_fair_spacing", int'(ovf), 0);

      // Two-cycle burst: ch0 is granted while its 2nd sample arrives, ch1..3 overrun.
      sb.push_back('{ch: 0, data: 31});
      sb.push_back('{ch: 1, data: 21});
      sb.push_back('{ch: 2, data: 23});
      sb.push_back('{ch: 3, data: 26});
      for (int k = 0; k < NUM_CH; k++) set_ch(k, firsts[k]);
      cyc(1);
      for (int k = 0; k < NUM_CH; k++) set_ch(k, 500);
      cyc(1);
      in_valid = '0;
      cyc(1);
      chk("ovf_burst", int'(ovf), 4'b1110);
      cyc(6);
      chk("ovf_sticky", int'(ovf), 4'b1110);
      ovf_clr = 1'b1;
      cyc(1);
      ovf_clr = 1'b0;
      chk("ovf_clr", int'(ovf), 0);

      // ch0 kept the 500: 500+3*100 -> ave 294 -> 73.
      sb.push_back('{ch: 0, data: 73});
      for (int i = 0; i < 3; i++) send_spaced(0, 100);
      cyc(2);

      // ch1 back-to-back samples, each arriving as the previous one is granted.
      do_clear();
      sb.push_back('{ch: 1, data: 6});
      set_ch(1, 10); cyc(1);
      set_ch(1, 20); cyc(1);
      set_ch(1, 30); cyc(1);
      set_ch(1, 40); cyc(1);
      in_valid = '0;
      cyc(4);
      chk("ovf_same_cycle_grant", int'(ovf), 0);

      // clear after 2 samples discards them; clear on the closing grant drops the output.
      do_clear();
      send_spaced(0, 100);
      send_spaced(0, 100);
      do_clear();
      for (int i = 0; i < 3; i++) send_spaced(0, 100);
      set_ch(0, 100);
      cyc(1);
      in_valid = '0;
      clear    = 1'b1;
      cyc(1);
      clear    = 1'b0;
      cyc(3);
      chk("clear_grant_no_out", int'(out_valid), 0);
      sb.push_back('{ch: 0, data: 25});
      for (int i = 0; i < 4; i++) send_spaced(0, 100);
      cyc(2);

      // Reset mid-block with pending holds and overruns.
      do_clear();
      send_spaced(3, 100);
      send_spaced(3, 100);
      for (int k = 0; k < NUM_CH; k++) set_ch(k, 300);
      cyc(1);
      for (int k = 0; k < NUM_CH; k++) set_ch(k, 300);
      cyc(1);
      in_valid = '0;
      chk("ovf_before_reset", int'(ovf), 4'b1110);
      reset_n = 1'b0;
      cyc(2);
      chk("mid_rst_out_data",  int'(out_data),  0);
      chk("mid_rst_out_ch",    int'(out_ch),    0);
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_ovf",       int'(ovf),       0);
      reset_n = 1'b1;
      cyc(2);
      sb.push_back('{ch: 3, data: 25});
      for (int i = 0; i < 4; i++) send_spaced(3, 100);
      cyc(6);

      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
